// File: rtl/linked_list_fifo_rsv_if.sv
// Request/response bundle for the shared-pool multi-queue FIFO.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface linked_list_fifo_rsv_if #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  logic                 push;
  logic [SEL_WIDTH-1:0] push_sel;
  logic [WIDTH-1:0]     data_in;
  logic                 pop;
  logic [SEL_WIDTH-1:0] pop_sel;
  logic [NUM_FIFOS-1:0] full;
  logic [NUM_FIFOS-1:0] empty;
  logic [WIDTH-1:0]     data_out;
  logic                 data_out_vld;
  logic [CNT_WIDTH-1:0] free_count;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output push, push_sel, data_in, pop, pop_sel,
    input  full, empty, data_out, data_out_vld, free_count, overflow, underflow
  );

  modport slave (
    input  push, push_sel, data_in, pop, pop_sel,
    output full, empty, data_out, data_out_vld, free_count, overflow, underflow
  );
endinterface

// File: rtl/linked_list_fifo_rsv.sv
// NUM_FIFOS linked-list queues sharing one DEPTH-entry pool, each queue
// guaranteed RESERVE entries; free entries are kept on their own linked list.
module linked_list_fifo_rsv #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int RESERVE   = 1
) (
  input logic                  clk,
  input logic                  rst,
  linked_list_fifo_rsv_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
  localparam int CNT_WIDTH = PTR_WIDTH + 1;

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef logic [SEL_WIDTH-1:0] sel_t;

  localparam cnt_t RSV = cnt_t'(RESERVE);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("linked_list_fifo_rsv: DEPTH must be a power of two >= 2");
  end
  if (NUM_FIFOS < 1 || NUM_FIFOS * RESERVE > DEPTH) begin : g_bad_reserve
    $error("linked_list_fifo_rsv: NUM_FIFOS*RESERVE exceeds DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             nxt [DEPTH];
  ptr_t             head  [NUM_FIFOS];
  ptr_t             tail  [NUM_FIFOS];
  cnt_t             count [NUM_FIFOS];
  ptr_t             free_head, free_tail;
  cnt_t             free_count;

  logic [WIDTH-1:0]     data_out;
  logic                 data_out_vld, overflow, underflow;
  logic [NUM_FIFOS-1:0] full, empty;
  cnt_t                 r_out;

  logic push_full, pop_empty, push_ok, pop_ok;
  ptr_t push_tail, pop_ent;
  cnt_t push_cnt, pop_cnt;
  logic same_q, free_empty_after;

  // Entries still owed to queues below their reservation.
  always_comb begin
    // NOTE: r_out is accumulated with blocking '=' so each loop iteration
    // sees the running sum; sequential state always uses '<='.
    r_out = '0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      if (count[q] < RSV) r_out = r_out + (RSV - count[q]);
    end
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment so no latch is inferred.
    full  = '0;
    empty = '0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      empty[q] = (count[q] == '0);
      full[q]  = !((count[q] < RSV) || (free_count > r_out));
    end
  end

  // Out-of-range selects (NUM_FIFOS not a power of two) are simply refused.
  always_comb begin
    push_full = 1'b1;
    pop_empty = 1'b1;
    push_tail = '0;
    push_cnt  = '0;
    pop_ent   = '0;
    pop_cnt   = '0;
    if (int'(bus.push_sel) < NUM_FIFOS) begin
      push_full = full[bus.push_sel];
      push_tail = tail[bus.push_sel];
      push_cnt  = count[bus.push_sel];
    end
    if (int'(bus.pop_sel) < NUM_FIFOS) begin
      pop_empty = empty[bus.pop_sel];
      pop_ent   = head[bus.pop_sel];
      pop_cnt   = count[bus.pop_sel];
    end
  end

  assign push_ok = bus.push & ~push_full;
  assign pop_ok  = bus.pop & ~pop_empty;
  assign same_q  = (bus.push_sel == bus.pop_sel);
  // The freed entry cannot serve this cycle's push, so if the push drains the
  // free list the freed entry starts a fresh one-element free list.
  assign free_empty_after = (free_count == '0) ||
                            (push_ok && free_count == cnt_t'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) nxt[i] <= ptr_t'(i + 1);
      for (int q = 0; q < NUM_FIFOS; q++) begin
        head[q]  <= '0;
        tail[q]  <= '0;
        count[q] <= '0;
      end
      free_head    <= '0;
      free_tail    <= ptr_t'(DEPTH - 1);
      free_count   <= cnt_t'(DEPTH);
      data_out     <= '0;
      data_out_vld <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      data_out_vld <= pop_ok;
      if (bus.push && !push_ok) overflow  <= 1'b1;
      if (bus.pop  && !pop_ok)  underflow <= 1'b1;

      if (push_ok) begin
        if (push_cnt == '0) head[bus.push_sel] <= free_head;
        else                nxt[push_tail]     <= free_head;
        tail[bus.push_sel] <= free_head;
      end

      if (pop_ok) begin
        data_out <= mem[pop_ent];
        // A lone entry popped while the same queue is pushed hands the head
        // to the new entry; nxt[pop_ent] is not yet linked to it.
        head[bus.pop_sel] <= (push_ok && same_q && pop_cnt == cnt_t'(1))
                             ? free_head : nxt[pop_ent];
        if (!free_empty_after) nxt[free_tail] <= pop_ent;
        free_tail <= pop_ent;
      end

      if (pop_ok && free_empty_after) free_head <= pop_ent;
      else if (push_ok)               free_head <= nxt[free_head];

      for (int q = 0; q < NUM_FIFOS; q++) begin
        count[q] <= count[q]
                  + cnt_t'(push_ok && bus.push_sel == sel_t'(q))
                  - cnt_t'(pop_ok  && bus.pop_sel  == sel_t'(q));
      end
      free_count <= free_count - cnt_t'(push_ok) + cnt_t'(pop_ok);
    end
  end

  // NOTE: the payload array is not reset; an entry is always written by its
  // push before any pop can read it.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[free_head] <= bus.data_in;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.data_out     = data_out;
  assign bus.data_out_vld = data_out_vld;
  assign bus.free_count   = free_count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;
endmodule

// File: tb/tb_linked_list_fifo_rsv.sv
// Directed and random checks of linked_list_fifo_rsv against a queue-based
// behavioural model of the shared pool with per-queue reservation.
module tb_linked_list_fifo_rsv;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int NF    = 2;
  localparam int RES   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  linked_list_fifo_rsv_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NF)) bus ();

  linked_list_fifo_rsv #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NF), .RESERVE(RES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_q [NF][$];
  logic [7:0] m_dout;
  logic       m_vld, m_ovf, m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_total();
    int t = 0;
    for (int q = 0; q < NF; q++) t += m_q[q].size();
    return t;
  endfunction

  function automatic logic m_full(input int q);
    int free = DEPTH - m_total();
    int owed = 0;
    for (int k = 0; k < NF; k++)
      if (m_q[k].size() < RES) owed += RES - m_q[k].size();
    return !(m_q[q].size() < RES || free > owed);
  endfunction

  task automatic model_reset();
    for (int q = 0; q < NF; q++) m_q[q].delete();
    m_dout = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [NF-1:0] ef, ee;
    for (int q = 0; q < NF; q++) begin
      ef[q] = m_full(q);
      ee[q] = (m_q[q].size() == 0);
    end
    check({tag, ".full"},       32'(bus.full),         32'(ef));
    check({tag, ".empty"},      32'(bus.empty),        32'(ee));
    check({tag, ".free_count"}, 32'(bus.free_count),   32'(DEPTH - m_total()));
    check({tag, ".vld"},        32'(bus.data_out_vld), 32'(m_vld));
    check({tag, ".data_out"},   32'(bus.data_out),     32'(m_dout));
    check({tag, ".overflow"},   32'(bus.overflow),     32'(m_ovf));
    check({tag, ".underflow"},  32'(bus.underflow),    32'(m_udf));
  endtask

  // One clock with the given requests; acceptance is judged on pre-edge state.
  task automatic step(input string tag, input logic p, input int ps, input logic [7:0] d,
                      input logic o, input int os);
    logic push_acc, pop_acc;
    bus.push = p; bus.push_sel = 1'(ps); bus.data_in = d;
    bus.pop  = o; bus.pop_sel  = 1'(os);
    push_acc = p && !m_full(ps);
    pop_acc  = o && (m_q[os].size() > 0);
    @(posedge clk); #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    m_vld = pop_acc;
    if (pop_acc) m_dout = m_q[os].pop_front();
    if (o && !pop_acc) m_udf = 1'b1;
    if (push_acc) m_q[ps].push_back(d);
    if (p && !push_acc) m_ovf = 1'b1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic with_traffic);
    rst = 1'b1;
    bus.push = with_traffic; bus.push_sel = 1'b0; bus.data_in = 8'h77;
    bus.pop  = with_traffic; bus.pop_sel  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    model_reset();
    check_all(tag);
    check({tag, ".rst_free"},  32'(bus.free_count), 32'(DEPTH));
    check({tag, ".rst_empty"}, 32'(bus.empty),      32'h3);
  endtask

  initial begin
    bus.push = 1'b0; bus.push_sel = '0; bus.data_in = '0;
    bus.pop  = 1'b0; bus.pop_sel  = '0;
    model_reset();
    @(posedge clk); #1;
    do_reset("reset", 1'b0);

    // Basic order
    step("bo_push1", 1, 0, 8'hA1, 0, 0);
    check("bo_free1", 32'(bus.free_count), 32'd3);
    step("bo_push2", 1, 0, 8'hA2, 0, 0);
    check("bo_free2", 32'(bus.free_count), 32'd2);
    step("bo_pop1", 0, 0, 8'h00, 1, 0);
    check("bo_data1", 32'(bus.data_out), 32'hA1);
    check("bo_free3", 32'(bus.free_count), 32'd3);
    step("bo_pop2", 0, 0, 8'h00, 1, 0);
    check("bo_data2", 32'(bus.data_out), 32'hA2);
    check("bo_vld2",  32'(bus.data_out_vld), 32'd1);
    check("bo_free4", 32'(bus.free_count), 32'd4);

    // Reservation: q0 may not consume q1's guaranteed entry
    for (int i = 0; i < 3; i++) step("rs_push_q0", 1, 0, 8'(8'h50 + i), 0, 0);
    check("rs_free1", 32'(bus.free_count), 32'd1);
    check("rs_full1", 32'(bus.full), 32'b01);
    step("rs_push_q1", 1, 1, 8'h60, 0, 0);
    check("rs_full2", 32'(bus.full), 32'b11);
    check("rs_free0", 32'(bus.free_count), 32'd0);

    // Overflow while full, held across idle cycles
    step("ov_push", 1, 0, 8'hEE, 0, 0);
    check("ov_flag", 32'(bus.overflow), 32'd1);
    check("ov_free", 32'(bus.free_count), 32'd0);
    for (int i = 0; i < 10; i++) step("ov_hold", 0, 0, 8'h00, 0, 0);
    check("ov_held", 32'(bus.overflow), 32'd1);

    // Pool empty: simultaneous push q1 / pop q0 -> only the pop is accepted
    step("f0_pushpop", 1, 1, 8'h55, 1, 0);
    check("f0_data", 32'(bus.data_out), 32'h50);
    check("f0_free", 32'(bus.free_count), 32'd1);
    // One free entry: push q0 / pop q1 both accepted
    step("f1_pushpop", 1, 0, 8'h66, 1, 1);
    check("f1_data", 32'(bus.data_out), 32'h60);
    check("f1_free", 32'(bus.free_count), 32'd1);
    for (int i = 0; i < 3; i++) step("f1_drain", 0, 0, 8'h00, 1, 0);
    check("f1_last", 32'(bus.data_out), 32'h66);

    // Underflow on an empty queue keeps data_out
    step("uf_pop", 0, 0, 8'h00, 1, 1);
    check("uf_flag", 32'(bus.underflow), 32'd1);
    check("uf_vld",  32'(bus.data_out_vld), 32'd0);
    check("uf_data", 32'(bus.data_out), 32'h66);
    do_reset("rst1", 1'b0);

    // Interleave
    step("il_p0", 1, 0, 8'h10, 0, 0);
    step("il_p1", 1, 1, 8'h20, 0, 0);
    step("il_p2", 1, 0, 8'h11, 0, 0);
    step("il_o1", 0, 0, 8'h00, 1, 1);
    check("il_d1", 32'(bus.data_out), 32'h20);
    step("il_o0a", 0, 0, 8'h00, 1, 0);
    check("il_d2", 32'(bus.data_out), 32'h10);
    step("il_o0b", 0, 0, 8'h00, 1, 0);
    check("il_d3", 32'(bus.data_out), 32'h11);
    check("il_empty", 32'(bus.empty), 32'b11);

    // Simultaneous push/pop on a one-entry queue
    step("sp_seed", 1, 0, 8'h33, 0, 0);
    step("sp_both", 1, 0, 8'h44, 1, 0);
    check("sp_data", 32'(bus.data_out), 32'h33);
    check("sp_free", 32'(bus.free_count), 32'd3);
    check("sp_empty", 32'(bus.empty), 32'b10);
    step("sp_pop", 0, 0, 8'h00, 1, 0);
    check("sp_data2", 32'(bus.data_out), 32'h44);
    // Push and pop of an empty queue: pop refused, push accepted
    step("sp_e", 1, 1, 8'h99, 1, 1);
    check("sp_e_udf", 32'(bus.underflow), 32'd1);
    check("sp_e_empty", 32'(bus.empty), 32'b01);

    // Reset mid-traffic with 3 entries queued and requests in flight
    step("rt_fill", 1, 0, 8'hC1, 0, 0);
    step("rt_fill", 1, 0, 8'hC2, 0, 0);
    do_reset("rst2", 1'b1);

    // Random legal traffic
    for (int n = 0; n < 200; n++) begin
      logic p, o;
      int ps, os;
      ps = int'($urandom_range(0, NF - 1));
      os = int'($urandom_range(0, NF - 1));
      p  = 1'($urandom_range(0, 1)) && !m_full(ps);
      o  = 1'($urandom_range(0, 1)) && (m_q[os].size() > 0);
      step("rnd", p, ps, 8'($urandom), o, os);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
